inst_buffer: RTL

Circular instruction FIFO directly downstream of the fetch stage. It accepts one registered fetch packet per cycle and holds it until dispatch pops it in program order. It generates the ib_full back-pressure that fetch uses to stop advancing its PC. It is cleared in one cycle on a pipeline squash, such as a branch redirect or mispredict recovery.

---
 rtl/inst_buffer_if.sv | 49 ++++
 rtl/inst_buffer.sv | 96 +++++++++
 2 files changed

// File: rtl/inst_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_buffer_pkg / inst_buffer_if
//  Description : Fetch-packet type shared by fetch, the instruction buffer and
//                dispatch, plus the bundle of signals between the
//                instruction buffer and its neighbours.
//                  master : fetch/dispatch side (drives squash, packet, pop)
//                  slave  : instruction buffer (drives full/empty/head/count)
//  Revision    : 1.0 - initial release
// ============================================================================
package inst_buffer_pkg;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
    logic        valid;
  } IF_IB_PACKET;

endpackage

interface inst_buffer_if #(
  parameter int DEPTH = 8
);
  import inst_buffer_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              squash;
  IF_IB_PACKET       if_ib_packet;
  logic              dp_pop;
  logic              ib_full;
  logic              ib_empty;
  IF_IB_PACKET       ib_dp_packet;
  logic [CNT_W-1:0]  ib_count;
  logic              overflow_err;

  modport master (
    output squash, if_ib_packet, dp_pop,
    input  ib_full, ib_empty, ib_dp_packet, ib_count, overflow_err
  );

  modport slave (
    input  squash, if_ib_packet, dp_pop,
    output ib_full, ib_empty, ib_dp_packet, ib_count, overflow_err
  );

endinterface
`default_nettype wire

// File: rtl/inst_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : inst_buffer
//  Description : Circular instruction FIFO between fetch and dispatch. Holds
//                fetch packets in program order, raises back-pressure one
//                entry early, and flushes in a single cycle on squash.
//  Ports       : clock, reset (sync, active-high)
//                ib.squash        flush all entries
//                ib.if_ib_packet  incoming fetch packet (push when .valid)
//                ib.dp_pop        dispatch consumes the head entry
//                ib.ib_full       back-pressure to fetch (count >= DEPTH-1)
//                ib.ib_empty      no entry at head
//                ib.ib_dp_packet  head entry, .valid = !ib_empty
//                ib.ib_count      occupancy 0..DEPTH
//                ib.overflow_err  sticky: a push was dropped while full
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic          clock,
  input  logic          reset,
  inst_buffer_if.slave  ib
);

  localparam int                PTR_W  = $clog2(DEPTH);
  localparam int                CNT_W  = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_HI  = CNT_W'(DEPTH - 1);

  IF_IB_PACKET       mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  logic              empty;
  logic              push_req;
  logic              push;
  logic              pop;
  IF_IB_PACKET       head_pkt;

  assign empty    = (count == '0);
  assign push_req = ib.if_ib_packet.valid;
  assign pop      = ib.dp_pop && !empty;
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign push     = push_req && ((count < CNT_MAX) || pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      // Cleared so the head fields never show X while the buffer is empty.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (ib.squash) begin
      // Same-cycle push/pop are discarded; the sticky error is left alone.
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= ib.if_ib_packet;
        tail      <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (push_req && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  // Stored entries always carry valid=1 and cleared ones valid=0, so gating
  // the stored bit with !empty yields exactly !empty.
  always_comb begin
    head_pkt       = mem[head];
    head_pkt.valid = mem[head].valid && !empty;
  end

  assign ib.ib_dp_packet = head_pkt;
  assign ib.ib_empty     = empty;
  // One entry of headroom covers the packet fetch already has in flight.
  assign ib.ib_full      = (count >= CNT_HI);
  assign ib.ib_count     = count;
  assign ib.overflow_err = overflow;

endmodule
`default_nettype wire
